snake_food_placer: RTL and testbench

Food-placement scheduler for the snake game. On request it picks a pseudo-random start cell on the 7x6 board and scans the game's occupancy bitmap from there, wrapping at the last cell, until it finds a free cell. It returns that cell as food X/Y, or reports that the board is full. It sits beside the game-logic state machine, which issues a request whenever the snake eats, and runs on the game-logic clock.

---
 rtl/snake_pkg.sv | 46 ++++
 rtl/snake_food_placer_if.sv | 23 ++
 rtl/snake_lfsr8.sv | 18 +
 rtl/snake_food_placer.sv | 100 ++++++++++
 tb/tb_snake_food_placer.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/snake_pkg.sv
// Shared grid constants, placer state encoding and cell-index helpers for the snake game.
package snake_pkg;

  localparam int GRID_COLS  = 7;
  localparam int GRID_ROWS  = 6;
  localparam int N_CELLS    = GRID_COLS * GRID_ROWS;
  localparam int CELL_IDX_W = 6;

  localparam logic [7:0] LFSR_MASK = 8'hB8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_RESULT
  } placer_state_t;

  typedef struct packed {
    logic [2:0] col;
    logic [2:0] row;
  } cell_pos_t;

  // Folds a free-running LFSR value onto 0..N_CELLS-1; only the low 6 bits matter.
  function automatic logic [CELL_IDX_W-1:0] lfsr_to_cell(input logic [7:0] lfsr);
    logic [CELL_IDX_W-1:0] raw;
    raw = lfsr[CELL_IDX_W-1:0];
    if (raw >= CELL_IDX_W'(N_CELLS)) lfsr_to_cell = raw - CELL_IDX_W'(N_CELLS);
    else                             lfsr_to_cell = raw;
  endfunction

  // Repeated subtraction instead of a divider; unrolls to GRID_ROWS compare/subtract steps.
  function automatic cell_pos_t idx_to_pos(input logic [CELL_IDX_W-1:0] idx);
    logic [CELL_IDX_W-1:0] rem;
    logic [2:0]            row;
    rem = idx;
    row = 3'd0;
    for (int i = 0; i < GRID_ROWS; i++) begin
      if (rem >= CELL_IDX_W'(GRID_COLS)) begin
        rem = rem - CELL_IDX_W'(GRID_COLS);
        row = row + 3'd1;
      end
    end
    idx_to_pos.col = rem[2:0];
    idx_to_pos.row = row;
  endfunction

endpackage

// File: rtl/snake_food_placer_if.sv
// Request/response bundle between the game-logic FSM (master) and the food placer (slave).
interface snake_food_placer_if;
  import snake_pkg::*;

  logic               i_Req;
  logic [N_CELLS-1:0] i_Body;
  logic               o_Busy;
  logic               o_Valid;
  logic               o_Full;
  logic [2:0]         o_Food_X;
  logic [2:0]         o_Food_Y;

  modport master (
    output i_Req, i_Body,
    input  o_Busy, o_Valid, o_Full, o_Food_X, o_Food_Y
  );

  modport slave (
    input  i_Req, i_Body,
    output o_Busy, o_Valid, o_Full, o_Food_X, o_Food_Y
  );

endinterface

// File: rtl/snake_lfsr8.sv
// 8-bit right-shifting Galois LFSR; shared by food and obstacle placement.
module snake_lfsr8
  import snake_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_En,
  output logic [7:0] o_Lfsr
);

  always_ff @(posedge i_Clk) begin
    if (i_Reset)   o_Lfsr <= SEED;
    else if (i_En) o_Lfsr <= {1'b0, o_Lfsr[7:1]} ^ (o_Lfsr[0] ? LFSR_MASK : 8'h00);
  end

endmodule

// File: rtl/snake_food_placer.sv
// Picks a pseudo-random start cell and scans a snapshot of the body bitmap for the next free cell.
module snake_food_placer
  import snake_pkg::*;
#(
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic                i_Clk,
  input  logic                i_Reset,
  snake_food_placer_if.slave  bus
);

  logic [7:0]            lfsr;
  logic [CELL_IDX_W-1:0] start_idx;
  cell_pos_t             start_pos;

  placer_state_t         state;
  logic [N_CELLS-1:0]    snap;
  logic [CELL_IDX_W-1:0] cursor;
  logic [CELL_IDX_W-1:0] checked;
  logic [2:0]            col;
  logic [2:0]            row;

  snake_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .i_En    (1'b1),
    .o_Lfsr  (lfsr)
  );

  assign start_idx = lfsr_to_cell(lfsr);
  assign start_pos = idx_to_pos(start_idx);

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state        <= ST_IDLE;
      snap         <= '0;
      cursor       <= '0;
      checked      <= '0;
      col          <= '0;
      row          <= '0;
      bus.o_Busy   <= 1'b0;
      bus.o_Valid  <= 1'b0;
      bus.o_Full   <= 1'b0;
      bus.o_Food_X <= '0;
      bus.o_Food_Y <= '0;
    end else begin
      bus.o_Valid <= 1'b0;
      bus.o_Full  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.i_Req) begin
            snap       <= bus.i_Body;
            cursor     <= start_idx;
            col        <= start_pos.col;
            row        <= start_pos.row;
            checked    <= '0;
            bus.o_Busy <= 1'b1;
            state      <= ST_SCAN;
          end
        end

        ST_SCAN: begin
          if (!snap[cursor]) begin
            bus.o_Food_X <= col;
            bus.o_Food_Y <= row;
            bus.o_Valid  <= 1'b1;
            state        <= ST_RESULT;
          end else if (checked == CELL_IDX_W'(N_CELLS - 1)) begin
            // This was the last unchecked cell, so the whole board is occupied.
            bus.o_Full <= 1'b1;
            state      <= ST_RESULT;
          end else begin
            checked <= checked + 1'b1;
            if (cursor == CELL_IDX_W'(N_CELLS - 1)) begin
              cursor <= '0;
              col    <= '0;
              row    <= '0;
            end else begin
              cursor <= cursor + 1'b1;
              if (col == 3'(GRID_COLS - 1)) begin
                col <= '0;
                row <= row + 3'd1;
              end else begin
                col <= col + 3'd1;
              end
            end
          end
        end

        ST_RESULT: begin
          bus.o_Busy <= 1'b0;
          state      <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_food_placer.sv
// Directed scoreboard bench for snake_food_placer: stimulus pushes predicted results, a monitor checks them.
module tb_snake_food_placer;
  import snake_pkg::*;

  logic i_Clk   = 1'b0;
  logic i_Reset = 1'b1;
  always #5 i_Clk = ~i_Clk;

  snake_food_placer_if bus();

  snake_food_placer #(.LFSR_SEED(8'hA5)) dut (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .bus     (bus)
  );

  typedef struct {
    bit         full;
    logic [2:0] x;
    logic [2:0] y;
    int         acc_cyc;
    int         res_cyc;
  } exp_t;

  exp_t       q[$];
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  logic [7:0] m_lfsr;
  bit         rst_q    = 1'b0;
  bit         skip_busy = 1'b0;
  logic [2:0] last_x = 3'd0, last_y = 3'd0;
  logic [2:0] st_x   = 3'd0, st_y   = 3'd0;

  function automatic logic [7:0] lstep(input logic [7:0] v);
    return v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
  endfunction

  // Reference LFSR and cycle counter, both advanced on the same edge as the DUT.
  always @(posedge i_Clk) begin
    cyc    <= cyc + 1;
    rst_q  <= i_Reset;
    m_lfsr <= i_Reset ? 8'hA5 : lstep(m_lfsr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one prediction per result pulse, otherwise checks idle/busy/hold behaviour.
  always @(negedge i_Clk) begin
    exp_t e;
    if (rst_q) begin
      chk("rst_busy",  bus.o_Busy,   0);
      chk("rst_valid", bus.o_Valid,  0);
      chk("rst_full",  bus.o_Full,   0);
      chk("rst_x",     bus.o_Food_X, 0);
      chk("rst_y",     bus.o_Food_Y, 0);
      last_x = 3'd0;
      last_y = 3'd0;
    end else if (bus.o_Valid || bus.o_Full) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_result valid=%0b full=%0b at cycle %0d", bus.o_Valid, bus.o_Full, cyc);
      end else begin
        e = q.pop_front();
        chk("full",    bus.o_Full,   e.full);
        chk("valid",   bus.o_Valid,  !e.full);
        chk("food_x",  bus.o_Food_X, e.x);
        chk("food_y",  bus.o_Food_Y, e.y);
        chk("latency", cyc,          e.res_cyc);
        chk("busy_at_result", bus.o_Busy, 1);
        last_x = e.x;
        last_y = e.y;
      end
    end else begin
      chk("hold_x", bus.o_Food_X, last_x);
      chk("hold_y", bus.o_Food_Y, last_y);
      if (!skip_busy)
        chk("busy", bus.o_Busy, (q.size() != 0 && cyc >= q[0].acc_cyc) ? 1 : 0);
    end
  end

  // Called at a negedge while the DUT is idle; the request is accepted at the next posedge.
  task automatic issue(input logic [N_CELLS-1:0] body, input bit push);
    int   s, k, idx;
    exp_t e;
    s = int'(m_lfsr[5:0]);
    if (s >= 42) s -= 42;
    e.full = 1'b1;
    e.x    = st_x;
    e.y    = st_y;
    k      = 42;
    for (int i = 0; i < 42; i++) begin
      idx = (s + i) % 42;
      if (!body[idx]) begin
        e.full = 1'b0;
        e.x    = 3'(idx % 7);
        e.y    = 3'(idx / 7);
        k      = i + 1;
        break;
      end
    end
    e.acc_cyc = cyc + 1;
    e.res_cyc = cyc + 1 + k;
    if (push) begin
      q.push_back(e);
      if (!e.full) begin
        st_x = e.x;
        st_y = e.y;
      end
    end
    bus.i_Body = body;
    bus.i_Req  = 1'b1;
    @(negedge i_Clk);
    bus.i_Req  = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 60; i++) begin
      if (q.size() == 0) break;
      @(negedge i_Clk);
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout pending=%0d expected=0", name, q.size());
      q.delete();
    end
    @(negedge i_Clk);
  endtask

  initial begin
    int  s, free;
    bit  hit;
    bus.i_Req  = 1'b0;
    bus.i_Body = '1;
    repeat (3) @(negedge i_Clk);
    i_Reset = 1'b0;
    @(negedge i_Clk);

    // Single free cell 20 -> (6,2)
    issue(~(42'd1 << 20), 1'b1);
    wait_done("single_free");

    // Empty board: result is the start cell after two edges
    issue('0, 1'b1);
    wait_done("empty_a");
    issue('0, 1'b1);
    wait_done("empty_b");

    // Full board: o_Full after 42 checks, food outputs unchanged
    issue('1, 1'b1);
    wait_done("full_board");

    // Start at 41 with only cell 0 free forces the 41->0 wrap
    hit = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (m_lfsr[5:0] == 6'd41) begin
        hit = 1'b1;
        break;
      end
      @(negedge i_Clk);
    end
    chk("start41_found", hit, 1);
    issue(~42'd1, 1'b1);
    wait_done("wrap");

    // Mid-scan body change and re-request are both ignored
    s = int'(m_lfsr[5:0]);
    if (s >= 42) s -= 42;
    free = (s + 30) % 42;
    issue(~(42'd1 << free), 1'b1);
    repeat (4) @(negedge i_Clk);
    bus.i_Body = '0;
    bus.i_Req  = 1'b1;
    @(negedge i_Clk);
    bus.i_Req  = 1'b0;
    wait_done("snapshot");

    // Reset mid-scan aborts the request with no result pulse
    skip_busy = 1'b1;
    issue('1, 1'b0);
    repeat (5) @(negedge i_Clk);
    i_Reset = 1'b1;
    @(negedge i_Clk);
    i_Reset   = 1'b0;
    skip_busy = 1'b0;
    st_x = 3'd0;
    st_y = 3'd0;
    repeat (60) @(negedge i_Clk);

    // Recovery after abort
    issue(~(42'd1 << 33), 1'b1);
    wait_done("recover");

    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
